// File: rtl/player_drawer.sv
// rtl/player_drawer.sv - erase-then-draw square sprite pixel generator
//
// Purpose: when start is seen in IDLE, this block first erases the previous
// sprite (if one was drawn) by streaming its SIZE*SIZE pixels in BG_COLOR.
// It then streams the new SIZE*SIZE pixels in the requested colour.
// Pixels are row-major with the column varying fastest. The requested
// position is clamped so the sprite always lies fully on screen.
//
// Ports:
//   clk              - sole clock, rising edge
//   resetn           - asynchronous active-low reset
//   start            - one-cycle move request (accepted only in IDLE)
//   new_x, new_y     - requested sprite top-left corner
//   color            - sprite colour
//   stall            - downstream not accepting; holds the current pixel
//   player_x_out     - current pixel x
//   player_y_out     - current pixel y
//   player_color_out - current pixel colour
//   player_busy      - high while a valid pixel is presented
//   done             - one-cycle pulse after the last pixel of a move
module player_drawer #(
    parameter int          SIZE     = 4,
    parameter logic [2:0]  BG_COLOR = 3'b000,
    parameter int          X_MAX    = 160,
    parameter int          Y_MAX    = 120
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] new_x,
    input  logic [6:0] new_y,
    input  logic [2:0] color,
    input  logic       stall,
    output logic [7:0] player_x_out,
    output logic [6:0] player_y_out,
    output logic [2:0] player_color_out,
    output logic       player_busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

    localparam logic [7:0] X_LIM = 8'(X_MAX - SIZE);
    localparam logic [6:0] Y_LIM = 7'(Y_MAX - SIZE);
    localparam logic [3:0] LAST  = 4'(SIZE - 1);

    state_t     state;
    logic [7:0] lat_x, old_x;
    logic [6:0] lat_y, old_y;
    logic [2:0] lat_color;
    logic       old_valid;
    logic [3:0] row, col;

    logic [7:0] clamp_x, base_x;
    logic [6:0] clamp_y, base_y;
    logic [3:0] nxt_row, nxt_col;
    logic       last_col, last_px;

    always_comb begin
        clamp_x  = (new_x > X_LIM) ? X_LIM : new_x;
        clamp_y  = (new_y > Y_LIM) ? Y_LIM : new_y;
        last_col = (col == LAST);
        last_px  = last_col && (row == LAST);
        nxt_col  = last_col ? 4'd0 : col + 4'd1;
        nxt_row  = last_col ? row + 4'd1 : row;
        // Pixel origin for the phase in progress.
        base_x   = (state == ERASE) ? old_x : lat_x;
        base_y   = (state == ERASE) ? old_y : lat_y;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state            <= IDLE;
            lat_x            <= '0;
            lat_y            <= '0;
            lat_color        <= '0;
            old_x            <= '0;
            old_y            <= '0;
            old_valid        <= 1'b0;
            row              <= '0;
            col              <= '0;
            player_x_out     <= '0;
            player_y_out     <= '0;
            player_color_out <= '0;
            player_busy      <= 1'b0;
            done             <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lat_x       <= clamp_x;
                        lat_y       <= clamp_y;
                        lat_color   <= color;
                        row         <= '0;
                        col         <= '0;
                        player_busy <= 1'b1;
                        // The first pixel goes out right away, so the pixel
                        // stream starts on the cycle after acceptance.
                        if (old_valid) begin
                            state            <= ERASE;
                            player_x_out     <= old_x;
                            player_y_out     <= old_y;
                            player_color_out <= BG_COLOR;
                        end else begin
                            state            <= DRAW;
                            player_x_out     <= clamp_x;
                            player_y_out     <= clamp_y;
                            player_color_out <= color;
                        end
                    end
                end
                ERASE, DRAW: begin
                    if (!stall) begin
                        if (last_px) begin
                            row <= '0;
                            col <= '0;
                            if (state == ERASE) begin
                                // No gap: the first draw pixel follows directly.
                                state            <= DRAW;
                                player_x_out     <= lat_x;
                                player_y_out     <= lat_y;
                                player_color_out <= lat_color;
                            end else begin
                                state       <= DONE;
                                player_busy <= 1'b0;
                                done        <= 1'b1;
                                old_x       <= lat_x;
                                old_y       <= lat_y;
                                old_valid   <= 1'b1;
                            end
                        end else begin
                            row          <= nxt_row;
                            col          <= nxt_col;
                            player_x_out <= base_x + {4'b0, nxt_col};
                            player_y_out <= base_y + {3'b0, nxt_row};
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/player_drawer.md
PLAYER_DRAWER -- requirements
Module: player_drawer

Interface
REQ-001 SHALL have parameter SIZE, default 4, sprite edge length in pixels (legal 1..8).
REQ-002 SHALL have parameter BG_COLOR, default 3'b000, erase colour.
REQ-003 SHALL have parameter X_MAX, default 160, screen width in pixels.
REQ-004 SHALL have parameter Y_MAX, default 120, screen height in pixels.
REQ-005 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  one-cycle request to move/draw sprite.
REQ-008 SHALL have port new_x  input  8  requested sprite top-left x.
REQ-009 SHALL have port new_y  input  7  requested sprite top-left y.
REQ-010 SHALL have port color  input  3  sprite colour.
REQ-011 SHALL have port stall  input  1  downstream (VGA) not accepting; freezes pixel stepping.
REQ-012 SHALL have port player_x_out  output  8  current pixel x.
REQ-013 SHALL have port player_y_out  output  7  current pixel y.
REQ-014 SHALL have port player_color_out  output  3  current pixel colour.
REQ-015 SHALL have port player_busy  output  1  high while a valid pixel is presented.
REQ-016 SHALL have port done  output  1  one-cycle pulse after last pixel of a move.

Function
REQ-017 SHALL implement states IDLE, ERASE, DRAW, DONE; all outputs registered.
REQ-018 In IDLE, start=1 SHALL latch clamped coords and color; next state ERASE if old_valid=1, else DRAW.
REQ-019 Clamp: x = min(new_x, X_MAX-SIZE), y = min(new_y, Y_MAX-SIZE), unsigned compare.
REQ-020 start SHALL be ignored in ERASE, DRAW, DONE (no queuing).
REQ-021 ERASE SHALL present SIZE*SIZE pixels at old_x+col, old_y+row, colour BG_COLOR, row-major (col fastest), row/col starting 0.
REQ-022 DRAW SHALL present SIZE*SIZE pixels at lat_x+col, lat_y+row, colour = latched color, same order.
REQ-023 First pixel SHALL appear on outputs the cycle after start is accepted; player_busy=1 for exactly that pixel span.
REQ-024 Each pixel SHALL be held while stall=1; counter advances only on cycles with stall=0 (pixel consumed).
REQ-025 Without stall, move SHALL take 2*SIZE*SIZE busy cycles (SIZE*SIZE if no erase); ERASE->DRAW with no gap cycle.
REQ-026 After last DRAW pixel consumed, state DONE for one cycle: done=1, player_busy=0, old_x/old_y := latched coords, old_valid := 1; then IDLE.
REQ-027 In IDLE and DONE, player_busy=0 and x/y/color outputs SHALL hold last values.
REQ-028 Pixel coords SHALL never exceed X_MAX-1 / Y_MAX-1 given clamping; adders sized to output width, no wrap.

Reset
REQ-029 resetn=0 SHALL immediately force state IDLE, player_x_out=0, player_y_out=0, player_color_out=0, player_busy=0, done=0, old_valid=0, old_x=0, old_y=0, counters 0.
REQ-030 Reset mid-ERASE/DRAW SHALL abandon the move; next start after release draws without erase.

Verification
REQ-031 After reset, start with new_x=10,new_y=20,color=3'b100, stall=0 -> 16 DRAW pixels (10..13,20..23) colour 100, busy 16 cycles, done pulse, no erase.
REQ-032 Second start new_x=11,new_y=20,color=3'b100 -> 16 erase pixels at (10..13,20..23) colour 000, then 16 draw pixels at (11..14,20..23), 32 busy cycles, done once.
REQ-033 start with new_x=200,new_y=127 -> drawn at x 156..159, y 116..119.
REQ-034 stall=1 for 5 cycles during pixel 3 of DRAW -> pixel 3 held 6 cycles, total sequence unchanged, done delayed by 5 cycles.
REQ-035 start pulsed again mid-DRAW -> ignored; exactly one done.
REQ-036 resetn low mid-ERASE -> outputs zero asynchronously; subsequent start yields DRAW only (SIZE*SIZE pixels).
